// File: rtl/pt_write_responder_pkg.sv
// pt_write_responder_pkg: frame constants, ZBT widths and FIFO entry type shared by the write responder.
package pt_write_responder_pkg;
    localparam int FRAME_H_PIX = 640;
    localparam int FRAME_V_PIX = 480;
    localparam int ZBT_ADDR_W = 19;
    localparam int ZBT_DATA_W = 36;
    localparam int PIXEL_W = 18;
    localparam int ENTRY_W = ZBT_ADDR_W + PIXEL_W;

    typedef struct packed {
        logic [ZBT_ADDR_W-1:0] addr;
        logic [PIXEL_W-1:0] pixel;
    } pt_entry_t;

    function automatic logic [ZBT_ADDR_W-1:0] pix_addr(input logic [9:0] x, input logic [8:0] y, input int h);
        return ZBT_ADDR_W'(y) * ZBT_ADDR_W'(h) + ZBT_ADDR_W'(x);
    endfunction
endpackage

// File: rtl/pt_wr_fifo.sv
// pt_wr_fifo: synchronous FIFO with occupancy count; a push into a full FIFO is accepted only alongside a pop.
module pt_wr_fifo #(
    parameter int DEPTH = 8,
    parameter int W = 37,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic push_ok, pop_ok;

    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    assign pop_ok = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout = mem[rd_ptr];

    always_ff @(posedge clk)
        if (push_ok) mem[wr_ptr] <= din;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
endmodule

// File: rtl/pt_write_responder.sv
// pt_write_responder: buffers projective-transform pixel writes and replays them as pipelined ZBT SRAM writes.
module pt_write_responder
    import pt_write_responder_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int H_PIX = FRAME_H_PIX,
    parameter int V_PIX = FRAME_V_PIX,
    parameter int ZBT_WLAT = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [PIXEL_W-1:0]    pt_pixel_write,
    input  logic [9:0]            pt_x,
    input  logic [8:0]            pt_y,
    input  logic                  pt_wr,
    output logic                  ptflag,
    output logic                  mem_req,
    input  logic                  mem_grant,
    output logic                  mem_we,
    output logic [ZBT_ADDR_W-1:0] mem_addr,
    output logic [ZBT_DATA_W-1:0] mem_data,
    output logic                  mem_data_oe,
    output logic                  overflow,
    output logic                  dropped
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic in_range, full, empty, push, pop;
    logic [CW-1:0] count, next_count;
    pt_entry_t entry, head;
    logic [PIXEL_W-1:0] pix_q;
    logic [PIXEL_W-1:0] dly_pix [ZBT_WLAT];
    logic [ZBT_WLAT-1:0] dly_v;

    assign in_range = int'(pt_x) < H_PIX && int'(pt_y) < V_PIX;
    assign pop = mem_grant && !empty;
    assign push = pt_wr && in_range && (!full || pop);
    assign entry = '{addr: pix_addr(pt_x, pt_y, H_PIX), pixel: pt_pixel_write};
    assign next_count = count + CW'(push) - CW'(pop);
    assign mem_req = !empty;
    assign mem_data = {{(ZBT_DATA_W-PIXEL_W){1'b0}}, dly_pix[ZBT_WLAT-1]};
    assign mem_data_oe = dly_v[ZBT_WLAT-1];

    pt_wr_fifo #(.DEPTH(DEPTH), .W(ENTRY_W)) u_fifo (
        .clk(clk),
        .reset(reset),
        .push(push),
        .pop(pop),
        .din(entry),
        .dout(head),
        .count(count),
        .full(full),
        .empty(empty)
    );

    // Data trails the address phase by ZBT_WLAT cycles through a shift line fed from the address stage.
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            ptflag <= 1'b1;
            overflow <= 1'b0;
            dropped <= 1'b0;
            mem_we <= 1'b0;
            mem_addr <= '0;
            pix_q <= '0;
            dly_v <= '0;
            for (int i = 0; i < ZBT_WLAT; i++) dly_pix[i] <= '0;
        end else begin
            ptflag <= (int'(next_count) <= DEPTH - 3);
            overflow <= overflow | (pt_wr && in_range && !push);
            dropped <= pt_wr && !in_range;
            mem_we <= pop;
            if (pop) begin
                mem_addr <= head.addr;
                pix_q <= head.pixel;
            end
            dly_v[0] <= mem_we;
            dly_pix[0] <= pix_q;
            for (int i = 1; i < ZBT_WLAT; i++) begin
                dly_v[i] <= dly_v[i-1];
                dly_pix[i] <= dly_pix[i-1];
            end
        end
endmodule
